// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its return stack.
package seq_pkg;

  localparam int unsigned PC_W      = 13;
  localparam int unsigned STK_DEPTH = 8;
  localparam int unsigned STK_PTR_W = 3;
  localparam int unsigned INST_W    = 8;

  localparam logic [PC_W-1:0] RESET_VEC = '0;

  // Four clocks per instruction cycle, encoded 0..3 on the phase output.
  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_e;

  typedef enum logic {
    StRun   = 1'b0,
    StSleep = 1'b1
  } state_e;

endpackage

// File: rtl/seq_ctrl_ret_stack.sv
// Return-address stack: 8 entries, wrapping 3-bit pointer, no overflow or underflow detection.
module ret_stack
  import seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top
);

  localparam logic [STK_PTR_W-1:0] PtrOne = 1;

  logic [PC_W-1:0]      mem_q [STK_DEPTH];
  logic [STK_PTR_W-1:0] ptr_q, ptr_d;
  logic [STK_PTR_W-1:0] top_idx;

  // Pointer addresses the next free slot; the top entry sits just below it.
  always_comb begin
    top_idx = ptr_q - PtrOne;
    top     = mem_q[top_idx];
  end

  // Pointer update; push wins if both are asserted (caller never does that).
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = ptr_q + PtrOne;
    end else if (pop) begin
      ptr_d = ptr_q - PtrOne;
    end
  end

  // Storage and pointer; a 9th push lands on the oldest entry by wrap-around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < STK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (push) begin
        mem_q[ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Four-phase instruction sequencer: fetch/execute overlap, branch flush, return stack, sleep.
module seq_ctrl
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] prog_data,
  input  logic              dec_wr_w,
  input  logic              dec_wr_f,
  input  logic              dec_goto,
  input  logic              dec_call,
  input  logic              dec_ret,
  input  logic              dec_skip,
  input  logic              skip_cond,
  input  logic [PC_W-1:0]   target,
  input  logic              sleep_req,
  input  logic              wake,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst_reg,
  output logic [1:0]        phase,
  output logic              w_we,
  output logic              f_we,
  output logic              flush,
  output logic              asleep
);

  localparam logic [PC_W-1:0] PcOne = 1;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic                flush_q, flush_d;

  logic [PC_W-1:0]     next_pc;
  logic [PC_W-1:0]     stk_top;
  logic                q4_run;
  logic                live;
  logic                redirect;
  logic                stk_push;
  logic                stk_pop;
  logic                enter_sleep;

  // Instruction-cycle boundary and qualification of the decoded controls.
  always_comb begin
    q4_run      = (state_q == StRun) && (phase_q == Q4);
    live        = !flush_q;
    // A flushed instruction is a NOP: its decode never redirects, pushes, pops or sleeps.
    redirect    = live && (dec_goto || dec_call || dec_ret || (dec_skip && skip_cond));
    stk_push    = q4_run && live && dec_call;
    stk_pop     = q4_run && live && dec_ret && !dec_goto && !dec_call;
    enter_sleep = q4_run && live && sleep_req && !wake;
  end

  // Fetch address for the next instruction cycle; pc+1 wraps in 13 bits.
  always_comb begin
    next_pc = pc_q + PcOne;
    if (live) begin
      if (dec_goto || dec_call) begin
        next_pc = target;
      end else if (dec_ret) begin
        next_pc = stk_top;
      end
    end
  end

  ret_stack u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q),
    .top       (stk_top)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: sleep only at a live Q4 without wake; any wake edge leaves sleep.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (enter_sleep) begin
          state_d = StSleep;
        end
      end
      StSleep: begin
        if (wake) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // FSM outputs: strobes only in the last phase of a live instruction.
  always_comb begin
    w_we   = (state_q == StRun) && (phase_q == Q4) && !flush_q && dec_wr_w;
    f_we   = (state_q == StRun) && (phase_q == Q4) && !flush_q && dec_wr_f;
    asleep = (state_q == StSleep);
  end

  // Datapath next values; everything holds while asleep, phase parks at Q1.
  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flush_d = flush_q;
    if (state_q == StRun) begin
      // Q4 wraps to Q1, which is also the phase we sleep in.
      phase_d = phase_e'(phase_q + 2'd1);
      if (phase_q == Q4) begin
        pc_d    = next_pc;
        ir_d    = prog_data;
        flush_d = redirect;
      end
    end
  end

  // Datapath registers; reset starts with a flushed dummy cycle at the reset vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= Q1;
      pc_q    <= RESET_VEC;
      ir_q    <= '0;
      flush_q <= 1'b1;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
    end
  end

  assign pc       = pc_q;
  assign inst_reg = ir_q;
  assign phase    = phase_q;
  assign flush    = flush_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: reset, strobes, goto, call/ret, skip, sleep, async reset.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  prog_data;
  logic        dec_wr_w = 1'b0, dec_wr_f = 1'b0, dec_goto = 1'b0, dec_call = 1'b0;
  logic        dec_ret = 1'b0, dec_skip = 1'b0, skip_cond = 1'b0;
  logic [12:0] target = '0;
  logic        sleep_req = 1'b0, wake = 1'b0;
  logic [12:0] pc;
  logic [7:0]  inst_reg;
  logic [1:0]  phase;
  logic        w_we, f_we, flush, asleep;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .prog_data (prog_data),
    .dec_wr_w  (dec_wr_w),
    .dec_wr_f  (dec_wr_f),
    .dec_goto  (dec_goto),
    .dec_call  (dec_call),
    .dec_ret   (dec_ret),
    .dec_skip  (dec_skip),
    .skip_cond (skip_cond),
    .target    (target),
    .sleep_req (sleep_req),
    .wake      (wake),
    .pc        (pc),
    .inst_reg  (inst_reg),
    .phase     (phase),
    .w_we      (w_we),
    .f_we      (f_we),
    .flush     (flush),
    .asleep    (asleep)
  );

  // Program memory contents: a fixed scramble of the address.
  function automatic logic [7:0] pmem(input logic [12:0] a);
    return a[7:0] ^ 8'h5a;
  endfunction

  assign prog_data = pmem(pc);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    dec_wr_w = 1'b0; dec_wr_f = 1'b0; dec_goto = 1'b0; dec_call = 1'b0;
    dec_ret = 1'b0; dec_skip = 1'b0; skip_cond = 1'b0; target = '0;
    sleep_req = 1'b0; wake = 1'b0;
  endtask

  // Pulse reset across one rising edge; the next rising edge is edge 1 of cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    dec_wr_w = 1'b1;
    reset = 1'b1;
    #1;
    n_total++; if (pc !== 13'h0000) $display("FAIL rst_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (inst_reg !== 8'h00) $display("FAIL rst_ir: got %h want 00", inst_reg); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL rst_phase: got %0d want 0", phase); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL rst_flush: got %b want 1", flush); else n_pass++;
    n_total++; if (asleep !== 1'b0) $display("FAIL rst_asleep: got %b want 0", asleep); else n_pass++;
    n_total++; if (w_we !== 1'b0) $display("FAIL rst_wwe: got %b want 0", w_we); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wr_strobe();
    logic exp_w;
    do_reset();
    dec_wr_w = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step(1);
      exp_w = (n >= 7) && ((n % 4) == 3);
      n_total++;
      if (w_we !== exp_w) $display("FAIL wr_strobe_edge%0d: got %b want %b", n, w_we, exp_w);
      else n_pass++;
      if ((n % 4) == 0) begin
        n_total++;
        if (pc !== 13'(n / 4)) $display("FAIL wr_pc_edge%0d: got %h want %h", n, pc, 13'(n / 4));
        else n_pass++;
      end
    end
    n_total++;
    if (inst_reg !== pmem(13'h0003)) $display("FAIL wr_ir: got %h want %h", inst_reg, pmem(13'h0003));
    else n_pass++;
  endtask

  task automatic test_goto();
    do_reset();
    step(20);
    n_total++; if (pc !== 13'h0005) $display("FAIL goto_pre_pc: got %h want 0005", pc); else n_pass++;
    dec_goto = 1'b1; target = 13'h0123; dec_wr_w = 1'b1; dec_wr_f = 1'b1;
    step(3);
    n_total++; if (w_we !== 1'b1) $display("FAIL goto_own_wwe: got %b want 1", w_we); else n_pass++;
    step(1);
    n_total++; if (pc !== 13'h0123) $display("FAIL goto_pc: got %h want 0123", pc); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL goto_flush: got %b want 1", flush); else n_pass++;
    // dec_goto stays high through the flushed cycle and must be ignored.
    step(3);
    n_total++; if (w_we !== 1'b0) $display("FAIL goto_flush_wwe: got %b want 0", w_we); else n_pass++;
    n_total++; if (f_we !== 1'b0) $display("FAIL goto_flush_fwe: got %b want 0", f_we); else n_pass++;
    step(1);
    dec_goto = 1'b0;
    n_total++; if (pc !== 13'h0124) $display("FAIL goto_pc_next: got %h want 0124", pc); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL goto_no_chain: got %b want 0", flush); else n_pass++;
    n_total++;
    if (inst_reg !== pmem(13'h0123)) $display("FAIL goto_ir: got %h want %h", inst_reg, pmem(13'h0123));
    else n_pass++;
  endtask

  task automatic test_call_ret();
    logic [12:0] t;
    do_reset();
    step(68);
    n_total++; if (pc !== 13'h0011) $display("FAIL call_pre_pc: got %h want 0011", pc); else n_pass++;
    dec_call = 1'b1; target = 13'h0200;
    step(4);
    dec_call = 1'b0;
    n_total++; if (pc !== 13'h0200) $display("FAIL call_pc: got %h want 0200", pc); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL call_flush: got %b want 1", flush); else n_pass++;
    step(4);
    n_total++; if (pc !== 13'h0201) $display("FAIL call_pc_next: got %h want 0201", pc); else n_pass++;
    dec_ret = 1'b1;
    step(4);
    dec_ret = 1'b0;
    n_total++; if (pc !== 13'h0011) $display("FAIL ret_pc: got %h want 0011", pc); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL ret_flush: got %b want 1", flush); else n_pass++;
    step(4);
    n_total++; if (pc !== 13'h0012) $display("FAIL ret_pc_next: got %h want 0012", pc); else n_pass++;
    // Nine nested calls; the first pushes 0x012, call i pushes target(i-1)+1.
    for (int i = 0; i < 9; i++) begin
      t = 13'h0300 + 13'(i * 16);
      dec_call = 1'b1; target = t;
      step(4);
      dec_call = 1'b0;
      n_total++; if (pc !== t) $display("FAIL nest_call%0d: got %h want %h", i, pc, t); else n_pass++;
      step(4);
    end
    dec_ret = 1'b1;
    step(4);
    dec_ret = 1'b0;
    n_total++; if (pc !== 13'h0371) $display("FAIL nest_ret9: got %h want 0371", pc); else n_pass++;
    step(4);
    dec_ret = 1'b1;
    step(4);
    dec_ret = 1'b0;
    n_total++; if (pc !== 13'h0361) $display("FAIL nest_ret8: got %h want 0361", pc); else n_pass++;
  endtask

  task automatic test_skip();
    do_reset();
    step(8);
    dec_skip = 1'b1; skip_cond = 1'b1; dec_wr_f = 1'b1;
    step(3);
    n_total++; if (f_we !== 1'b1) $display("FAIL skip_own_fwe: got %b want 1", f_we); else n_pass++;
    step(1);
    n_total++; if (pc !== 13'h0003) $display("FAIL skip_pc: got %h want 0003", pc); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL skip_flush: got %b want 1", flush); else n_pass++;
    step(3);
    n_total++; if (f_we !== 1'b0) $display("FAIL skip_flushed_fwe: got %b want 0", f_we); else n_pass++;
    step(1);
    n_total++; if (flush !== 1'b0) $display("FAIL skip_no_chain: got %b want 0", flush); else n_pass++;
    n_total++; if (pc !== 13'h0004) $display("FAIL skip_pc2: got %h want 0004", pc); else n_pass++;
    skip_cond = 1'b0;
    step(3);
    n_total++; if (f_we !== 1'b1) $display("FAIL noskip_fwe: got %b want 1", f_we); else n_pass++;
    step(1);
    n_total++; if (flush !== 1'b0) $display("FAIL noskip_flush: got %b want 0", flush); else n_pass++;
    n_total++; if (pc !== 13'h0005) $display("FAIL noskip_pc: got %h want 0005", pc); else n_pass++;
    step(3);
    n_total++; if (f_we !== 1'b1) $display("FAIL noskip_next_fwe: got %b want 1", f_we); else n_pass++;
  endtask

  task automatic test_sleep();
    do_reset();
    step(8);
    sleep_req = 1'b1;
    step(4);
    sleep_req = 1'b0;
    n_total++; if (asleep !== 1'b1) $display("FAIL sleep_asleep: got %b want 1", asleep); else n_pass++;
    n_total++; if (pc !== 13'h0003) $display("FAIL sleep_pc: got %h want 0003", pc); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL sleep_phase: got %0d want 0", phase); else n_pass++;
    n_total++;
    if (inst_reg !== pmem(13'h0002)) $display("FAIL sleep_ir: got %h want %h", inst_reg, pmem(13'h0002));
    else n_pass++;
    dec_wr_w = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      n_total++;
      if (pc !== 13'h0003 || w_we !== 1'b0 || asleep !== 1'b1 || phase !== 2'd0)
        $display("FAIL sleep_hold%0d: pc=%h w_we=%b asleep=%b phase=%0d want 0003 0 1 0",
                 n, pc, w_we, asleep, phase);
      else n_pass++;
    end
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    n_total++; if (asleep !== 1'b0) $display("FAIL wake_asleep: got %b want 0", asleep); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL wake_phase: got %0d want 0", phase); else n_pass++;
    step(3);
    n_total++; if (w_we !== 1'b1) $display("FAIL wake_wwe: got %b want 1", w_we); else n_pass++;
    step(1);
    n_total++; if (pc !== 13'h0004) $display("FAIL wake_pc: got %h want 0004", pc); else n_pass++;
    sleep_req = 1'b1; wake = 1'b1;
    step(4);
    sleep_req = 1'b0; wake = 1'b0;
    n_total++; if (asleep !== 1'b0) $display("FAIL sleepwake_asleep: got %b want 0", asleep); else n_pass++;
    n_total++; if (pc !== 13'h0005) $display("FAIL sleepwake_pc: got %h want 0005", pc); else n_pass++;
    step(1);
    n_total++; if (phase !== 2'd1) $display("FAIL sleepwake_phase: got %0d want 1", phase); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4);
    dec_goto = 1'b1; target = 13'h0abc;
    step(4);
    dec_goto = 1'b0;
    step(2);
    n_total++;
    if (phase !== 2'd2 || flush !== 1'b1 || pc !== 13'h0abc)
      $display("FAIL arst_pre: phase=%0d flush=%b pc=%h want 2 1 0abc", phase, flush, pc);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (pc !== 13'h0000) $display("FAIL arst_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL arst_phase: got %0d want 0", phase); else n_pass++;
    n_total++; if (inst_reg !== 8'h00) $display("FAIL arst_ir: got %h want 00", inst_reg); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    // Populate one stack entry, then go to sleep.
    step(8);
    dec_call = 1'b1; target = 13'h0040;
    step(4);
    dec_call = 1'b0;
    step(4);
    sleep_req = 1'b1;
    step(4);
    sleep_req = 1'b0;
    n_total++; if (asleep !== 1'b1) $display("FAIL arst_sleep_pre: got %b want 1", asleep); else n_pass++;
    step(2);
    #2 reset = 1'b1;
    #1;
    n_total++; if (asleep !== 1'b0) $display("FAIL arst_sl_asleep: got %b want 0", asleep); else n_pass++;
    n_total++; if (pc !== 13'h0000) $display("FAIL arst_sl_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL arst_sl_flush: got %b want 1", flush); else n_pass++;
    n_total++; if (inst_reg !== 8'h00) $display("FAIL arst_sl_ir: got %h want 00", inst_reg); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    // Stack must be cleared: a return now lands on address 0.
    step(4);
    dec_ret = 1'b1;
    step(4);
    dec_ret = 1'b0;
    n_total++; if (pc !== 13'h0000) $display("FAIL arst_stack: got %h want 0000", pc); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wr_strobe();
    test_goto();
    test_call_ret();
    test_skip();
    test_sleep();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port prog_data, input, 8: program-memory word at address pc.
REQ-004 SHALL have port dec_wr_w, input, 1: decoded instruction writes W.
REQ-005 SHALL have port dec_wr_f, input, 1: decoded instruction writes file register.
REQ-006 SHALL have port dec_goto, input, 1: decoded instruction is an unconditional jump.
REQ-007 SHALL have port dec_call, input, 1: decoded instruction is a subroutine call.
REQ-008 SHALL have port dec_ret, input, 1: decoded instruction is a return.
REQ-009 SHALL have port dec_skip, input, 1: decoded instruction is a conditional skip.
REQ-010 SHALL have port skip_cond, input, 1: ALU skip condition is true.
REQ-011 SHALL have port target, input, 13: jump or call destination.
REQ-012 SHALL have port sleep_req, input, 1: decoded instruction is a sleep.
REQ-013 SHALL have port wake, input, 1: wake-up event.
REQ-014 SHALL have port pc, output, 13: fetch address.
REQ-015 SHALL have port inst_reg, output, 8: instruction currently executing.
REQ-016 SHALL have port phase, output, 2: Q1..Q4 encoded as 0..3.
REQ-017 SHALL have port w_we, output, 1: W write strobe.
REQ-018 SHALL have port f_we, output, 1: file write strobe.
REQ-019 SHALL have port flush, output, 1: current inst_reg is a discarded, NOP'd instruction.
REQ-020 SHALL have port asleep, output, 1: sequencer is in the SLEEP state.

Function
REQ-021 SHALL use FSM states RUN and SLEEP; in RUN, phase increments every clock and wraps 3->0.
REQ-022 SHALL treat one instruction cycle as 4 clocks; fetch of pc overlaps execution of inst_reg.
REQ-023 SHALL, on the clock edge ending Q4 in RUN, load inst_reg <= prog_data and pc <= next_pc.
REQ-024 SHALL compute next_pc as follows: if flush, pc+1; else dec_goto or dec_call -> target; else dec_ret -> stack top; else pc+1. The 13-bit value wraps, so 0x1FFF+1 = 0x0000.
REQ-025 SHALL, on a non-flushed dec_call, push the current pc (the return address) onto an 8-entry stack at that same Q4 edge.
REQ-026 SHALL wrap the stack pointer modulo 8: a 9th push overwrites the oldest entry, and a pop of an empty stack returns the wrapped entry with no error.
REQ-027 SHALL set flush for the next cycle when a non-flushed instruction has dec_goto, dec_call, dec_ret, or (dec_skip and skip_cond); otherwise flush SHALL be cleared at Q4.
REQ-028 SHALL, while flush=1, ignore all dec_* inputs, sleep_req and skip_cond; a flushed cycle never chains another flush.
REQ-029 SHALL drive w_we = (state==RUN) & (phase==3) & !flush & dec_wr_w, combinationally; f_we SHALL be identical using dec_wr_f.
REQ-030 SHALL, when sleep_req is high at Q4 of a non-flushed cycle and wake is low, still perform the REQ-023 update, then enter SLEEP with phase=0.
REQ-031 SHALL, in SLEEP, hold pc, inst_reg, phase and stack, keep w_we=f_we=0 and asleep=1.
REQ-032 SHALL return to RUN on the first edge with wake=1 while in SLEEP, resuming at Q1; wake in RUN has no effect except to suppress sleep entry (REQ-030).

Reset
REQ-033 SHALL, when reset is asserted (at any time, mid-cycle or in SLEEP), immediately set pc=0, inst_reg=0x00, phase=0, state=RUN, asleep=0, stack entries and pointer to 0, and flush=1 (first cycle is a dummy fetch).
REQ-034 SHALL execute address 0 in the second instruction cycle after reset release; its write strobe falls at clock 7.

Structure
REQ-035 SHALL place the phase enum (Q1..Q4), state enum (RUN/SLEEP), PC_W=13, STK_DEPTH=8 and RESET_VEC=0 in shared package seq_pkg.
REQ-036 SHALL implement the return stack as sub-module ret_stack (push, pop, top, wrapping 3-bit pointer).

Verification
REQ-037 SHALL cover: reset pulse, then dec_wr_w=1 held -> w_we low in cycle 0 (flush), w_we high only at clock 7, then every 4th clock; pc=1,2,3.
REQ-038 SHALL cover: dec_goto with target=0x0123 executing at pc=5 -> the next cycle is flushed (no strobes), then pc=0x0123, then 0x0124.
REQ-039 SHALL cover: call to 0x0200 from pc=0x0011, then ret -> pc returns to 0x0011 after one flush cycle; 9 nested calls then 1 ret -> return address of the 9th call.
REQ-040 SHALL cover: dec_skip=1 with skip_cond=1 -> next instruction flushed (f_we=0), pc advances by 1 normally; with skip_cond=0 -> no flush.
REQ-041 SHALL cover: sleep_req at Q4 -> asleep=1, pc frozen for 20 clocks; wake pulse -> phase=0 next clock, execution resumes; sleep_req+wake together -> no sleep.
REQ-042 SHALL cover: reset asserted at phase=2 during a flush and while in SLEEP -> all outputs take REQ-033 values asynchronously.
